mem_arbiter: RTL

//   Shares one external memory port between the MIPS_Pipeline I-cache miss path (read-only) and
//   D-cache miss/writeback path (read/write). Serialises requests, one memory transaction at a time,
//   and drives per-requester stall until its transaction completes. Sits between caches and memory.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose : shares one external memory port between the I-cache miss path
//           (read only) and the D-cache miss/writeback path (read/write).
//           One memory transaction at a time; each requester is stalled until
//           its own transaction has completed.
// Ports   : clk, rst (async, active high)
//           i_ren/i_addr -> i_rdata/i_stall           I-cache side
//           d_ren/d_wen/d_addr/d_wdata -> d_rdata/d_stall   D-cache side
//           mem_read/mem_write/mem_addr/mem_wdata -> memory (registered)
//           mem_rdata/mem_ready <- memory
// Config  : ARB_ROUND_ROBIN_EN defined   -> on contention grant the port that
//                                          was not served last
//           ARB_ROUND_ROBIN_EN undefined -> fixed priority, D-cache wins
module mem_arbiter #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   owner_i;   // 1: I-cache owns/last owned the port, 0: D-cache
    logic   req_i;
    logic   req_d;
    logic   grant_i;

    assign req_i = i_ren;
    assign req_d = d_ren | d_wen;

    // Arbitration: only consulted in IDLE when at least one request is up.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (req_i && req_d) begin
            grant_i = ~owner_i;
        end else begin
            grant_i = req_i;
        end
`else
        grant_i = req_i & ~req_d;
`endif
    end

    // Transaction FSM with registered memory strobes and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_i   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        owner_i <= grant_i;
                        state   <= SERVE;
                        if (grant_i) begin
                            mem_addr  <= i_addr;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end else begin
                            // read+write together is a write; no read data returned
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_write <= d_wen;
                            mem_read  <= ~d_wen;
                        end
                    end
                end
                SERVE: begin
                    if (mem_ready) begin
                        if (mem_read) begin
                            if (owner_i) begin
                                i_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= mem_rdata;
                            end
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall releases only in the single RESP cycle of the requester's own transaction.
    assign i_stall = req_i & ~((state == RESP) &  owner_i);
    assign d_stall = req_d & ~((state == RESP) & ~owner_i);

endmodule
